// File: rtl/fp_normalize_pack.sv
// Normalizes a raw add/sub mantissa, rounds, and packs an IEEE 754 half result.
// Latency 2 (zero/flush) or 3 (normal/carry) cycles from accept, plus 1 per extra left-shift step.
// Backpressure: result is held in DONE until out_ready; in_ready is low in every state except IDLE.
//
// Ports:
//   clk, rst_n                  : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready           : operand handshake (sign, 5-bit exp, 14-bit mantissa, sticky)
//   out_valid/out_ready         : result handshake
//   out_result                  : {sign, exp[4:0], frac[9:0]}
//   out_flags                   : {overflow, underflow, zero}
//
// Parameter LZ_STEP (1, 2 or 4) bounds the left shift applied per NORM cycle.
// Macro FP_NORM_RNE_EN selects round-to-nearest-even; undefined means truncate.

module fp_normalize_pack #(
    parameter int LZ_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [4:0]  in_exp,
    input  logic [13:0] in_mant,
    input  logic        in_sticky,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    localparam logic [3:0] STEP = 4'(LZ_STEP);

    state_t      state, state_nxt;
    logic        sign_r, sign_nxt;
    logic [5:0]  exp_r, exp_nxt;      // one spare bit so carry/round increments cannot wrap
    logic [13:0] mant_r, mant_nxt;
    logic        sticky_r, sticky_nxt;
    logic [15:0] result_nxt;
    logic [2:0]  flags_nxt;

    logic [3:0]  lz;
    logic [3:0]  shift_amt;
    logic        round_up;
    logic [11:0] rnd_sum;
    logic [10:0] rnd_mant;
    logic [5:0]  exp_rnd;

    // Leading zeros of mant[12:0], counted from the integer bit down (13 when all zero).
    function automatic logic [3:0] lzc13(input logic [12:0] m);
        logic [3:0] n;
        logic       found;
        n     = 4'd0;
        found = 1'b0;
        for (int i = 12; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      n = n + 4'd1;
            end
        end
        return n;
    endfunction

    always_comb begin
        lz        = lzc13(mant_r[12:0]);
        shift_amt = (lz < STEP) ? lz : STEP;

`ifdef FP_NORM_RNE_EN
        round_up = mant_r[1] && (mant_r[0] || sticky_r || mant_r[2]);
`else
        round_up = 1'b0;
`endif

        rnd_sum = {1'b0, mant_r[12:2]} + {11'b0, round_up};
        // A carry out of the integer bit renormalizes to exactly 1.0 at the next exponent.
        if (rnd_sum[11]) begin
            rnd_mant = 11'h400;
            exp_rnd  = exp_r + 6'd1;
        end else begin
            rnd_mant = rnd_sum[10:0];
            exp_rnd  = exp_r;
        end
    end

    always_comb begin
        state_nxt  = state;
        sign_nxt   = sign_r;
        exp_nxt    = exp_r;
        mant_nxt   = mant_r;
        sticky_nxt = sticky_r;
        result_nxt = out_result;
        flags_nxt  = out_flags;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nxt   = in_sign;
                    exp_nxt    = {1'b0, in_exp};
                    mant_nxt   = in_mant;
                    sticky_nxt = in_sticky;
                    state_nxt  = NORM;
                end
            end

            NORM: begin
                if (mant_r[13]) begin
                    mant_nxt   = {1'b0, mant_r[13:1]};
                    sticky_nxt = sticky_r | mant_r[0];
                    exp_nxt    = exp_r + 6'd1;
                    state_nxt  = ROUND;
                end else if (mant_r == 14'd0 && !sticky_r) begin
                    result_nxt = {sign_r, 15'h0000};
                    flags_nxt  = 3'b001;
                    state_nxt  = DONE;
                end else if (mant_r[12] && exp_r != 6'd0) begin
                    state_nxt  = ROUND;
                end else if (exp_r == 6'd0 || exp_r <= {2'b00, shift_amt}) begin
                    // No subnormal outputs: anything that would leave exp < 1 flushes to zero.
                    result_nxt = {sign_r, 15'h0000};
                    flags_nxt  = 3'b010;
                    state_nxt  = DONE;
                end else begin
                    mant_nxt   = mant_r << shift_amt;
                    exp_nxt    = exp_r - {2'b00, shift_amt};
                end
            end

            ROUND: begin
                mant_nxt = {1'b0, rnd_mant, 2'b00};
                exp_nxt  = exp_rnd;
                if (exp_rnd >= 6'd31) begin
                    result_nxt = {sign_r, 5'h1F, 10'h000};
                    flags_nxt  = 3'b100;
                end else begin
                    result_nxt = {sign_r, exp_rnd[4:0], rnd_mant[9:0]};
                    flags_nxt  = 3'b000;
                end
                state_nxt = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    flags_nxt = 3'b000;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sign_r     <= 1'b0;
            exp_r      <= 6'd0;
            mant_r     <= 14'd0;
            sticky_r   <= 1'b0;
            out_result <= 16'h0000;
            out_flags  <= 3'b000;
        end else begin
            state      <= state_nxt;
            sign_r     <= sign_nxt;
            exp_r      <= exp_nxt;
            mant_r     <= mant_nxt;
            sticky_r   <= sticky_nxt;
            out_result <= result_nxt;
            out_flags  <= flags_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Bench for fp_normalize_pack: table of operands with expected half results, flags and latency.
// Expected results are queued at accept time and popped when out_valid rises.
// Hand sequences cover reset state, output backpressure and reset during NORM.

module tb_fp_normalize_pack;

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [13:0] m;
        logic        st;
        logic [15:0] res;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [13:0] in_mant;
    logic        in_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_flags;

    int   total = 0;
    int   bad   = 0;
    vec_t sb[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    fp_normalize_pack #(.LZ_STEP(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_sticky  (in_sticky),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        int waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        in_sign   = v.s;
        in_exp    = v.e;
        in_mant   = v.m;
        in_sticky = v.st;
        in_valid  = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Returns the accept-relative edge count after which out_valid was seen.
    task automatic wait_out(output int edges);
        edges = 1;
        @(negedge clk);
        while (!out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic collect(input string name, input bit handshake);
        int   edges;
        vec_t v;
        wait_out(edges);
        check({name, "_out_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            check({name, "_scoreboard_nonempty"}, 32'd0, 32'd1);
        end else begin
            v = sb.pop_front();
            check({name, "_result"}, 32'(out_result), 32'(v.res));
            check({name, "_flags"}, 32'(out_flags), 32'(v.fl));
            check({name, "_latency"}, 32'(edges), 32'(v.lat));
            check({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
        end
        if (handshake) begin
            @(negedge clk);
            check({name, "_valid_after_hs"}, 32'(out_valid), 32'd0);
            check({name, "_flags_after_hs"}, 32'(out_flags), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 5'd15, 14'b10_0000000000_00, 1'b0, 16'h4000, 3'b000, 3};
        vecs[1]  = '{1'b0, 5'd15, 14'b00_0000000001_00, 1'b0, 16'h1400, 3'b000, 13};
`ifdef FP_NORM_RNE_EN
        vecs[2]  = '{1'b0, 5'd15, 14'b01_0000000001_10, 1'b0, 16'h3C02, 3'b000, 3};
        vecs[3]  = '{1'b0, 5'd15, 14'b01_1111111111_11, 1'b0, 16'h4000, 3'b000, 3};
`else
        vecs[2]  = '{1'b0, 5'd15, 14'b01_0000000001_10, 1'b0, 16'h3C01, 3'b000, 3};
        vecs[3]  = '{1'b0, 5'd15, 14'b01_1111111111_11, 1'b0, 16'h3FFF, 3'b000, 3};
`endif
        vecs[4]  = '{1'b0, 5'd30, 14'b11_1111111111_11, 1'b0, 16'h7C00, 3'b100, 3};
        vecs[5]  = '{1'b1, 5'd15, 14'b00_0000000000_00, 1'b0, 16'h8000, 3'b001, 2};
        vecs[6]  = '{1'b1, 5'd0,  14'b01_0000000000_00, 1'b0, 16'h8000, 3'b010, 2};
        vecs[7]  = '{1'b0, 5'd2,  14'b00_0100000000_00, 1'b0, 16'h0000, 3'b010, 3};
        vecs[8]  = '{1'b0, 5'd10, 14'b00_1000000001_00, 1'b0, 16'h2402, 3'b000, 4};
        vecs[9]  = '{1'b0, 5'd15, 14'b01_0000000000_10, 1'b0, 16'h3C00, 3'b000, 3};
        vecs[10] = '{1'b0, 5'd15, 14'b11_0000000000_01, 1'b0, 16'h4200, 3'b000, 3};
        vecs[11] = '{1'b0, 5'd3,  14'b00_0000000000_00, 1'b1, 16'h0000, 3'b010, 4};
        vecs[12] = '{1'b1, 5'd20, 14'b01_0101010101_00, 1'b0, 16'hD155, 3'b000, 3};

        // Reset with a valid operand presented: it must be ignored.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sign   = 1'b1;
        in_exp    = 5'd15;
        in_mant   = 14'h1000;
        in_sticky = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_result", 32'(out_result), 32'h0000);
        check("reset_out_flags", 32'(out_flags), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 13; i++) begin
            send(vecs[i]);
            collect($sformatf("vec%0d", i), 1'b1);
        end

        // Output backpressure: result held stable for five stalled cycles.
        out_ready = 1'b0;
        send(vecs[0]);
        collect("bp", 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_result", k), 32'(out_result), 32'h4000);
            check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset while the long operand is still normalizing.
        send(vecs[1]);
        repeat (3) @(negedge clk);
        check("mid_norm_valid", 32'(out_valid), 32'd0);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sign   = 1'b0;
        in_exp    = 5'd15;
        in_mant   = 14'h1000;
        @(negedge clk);
        check("norm_reset_out_valid", 32'(out_valid), 32'd0);
        check("norm_reset_out_result", 32'(out_result), 32'h0000);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("norm_reset_in_ready", 32'(in_ready), 32'd1);
        check("norm_reset_no_output", 32'(out_valid), 32'd0);

        // Recovery after the aborted operand.
        send(vecs[8]);
        collect("recover", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
